// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned CntWDefault = 16;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect (
    input  logic [2:0] id_rs_i,
    input  logic       id_rs_used_i,
    input  logic [2:0] id_rt_i,
    input  logic       id_rt_used_i,
    input  logic [2:0] idex_rd_i,
    input  logic       idex_regwrt_i,
    input  logic       idex_memread_i,
    output logic       load_use_o
);

    logic rs_hit;
    logic rt_hit;

    // Register 0 is an ordinary register here; no zero-register exemption.
    always_comb begin
        rs_hit     = id_rs_used_i && (id_rs_i == idex_rd_i);
        rt_hit     = id_rt_used_i && (id_rt_i == idex_rd_i);
        load_use_o = idex_memread_i && idex_regwrt_i && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencing: load-use bubbles, EX redirects, memory stalls and halt drain.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       idex_rd,
    input  logic             idex_regwrt,
    input  logic             idex_memread,
    input  logic             ex_redirect,
    input  logic             id_halt,
    input  logic             wb_halt,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs_i        (id_rs),
        .id_rs_used_i   (id_rs_used),
        .id_rt_i        (id_rt),
        .id_rt_used_i   (id_rt_used),
        .idex_rd_i      (idex_rd),
        .idex_regwrt_i  (idex_regwrt),
        .idex_memread_i (idex_memread),
        .load_use_o     (load_use)
    );

    // Mealy latch controls and next state; reset forces every enable and flush low.
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_d    = state_q;

        if (rst) begin
            unique case (state_q)
                StRun: begin
                    if (dmem_stall) begin
                        // Full freeze: MEM instruction still owns the data port.
                    end else if (ex_redirect) begin
                        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID one cycle; the load leaves EX on this edge.
                        {idex_we, exmem_we, memwb_we} = 3'b111;
                        idex_flush = 1'b1;
                    end else if (imem_stall) begin
                        {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
                        ifid_flush = 1'b1;
                    end else begin
                        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                    end
                    if (!dmem_stall && !ex_redirect && !load_use && id_halt) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (dmem_stall) begin
                        // Freeze, same as in RUN.
                    end else if (ex_redirect) begin
                        // Halt was on a wrong path: take the redirect and resume fetching.
                        {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
                        ifid_flush = 1'b1;
                    end
                    if (!dmem_stall && ex_redirect) begin
                        state_d = StRun;
                    end else if (wb_halt) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // Counter next values; both freeze in HALTED and clear under reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (state_q == StRun || state_q == StDrain) begin
            if (!pc_we) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush || idex_flush) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == StHalted);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
